aes_key_expand_seq: RTL and testbench
=====================================

Name: aes_key_expand_seq

Overview:
- Sequential AES key schedule (FIPS-197 KeyExpansion) for AES-128, AES-192 and AES-256.
- Generates one 32-bit schedule word per clock.
- Presents the complete schedule as one flat 1920-bit bus, with word j at bits [32*j+31 : 32*j].
- Sits directly upstream of the AddRoundKey stage, which indexes that bus by round number; the consumer may use the bus only while done=1.

Parameters:
- MAX_WORDS, 60, schedule capacity in words, equal to 4*(14+1). Fixed; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new expansion; sampled only in IDLE or DONE.
- key_size  input  2  key length: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = reserved, treated as 0.
- key  input  256  cipher key, left-aligned: key word i = key[255-32*i -: 32] for i < Nk; unused low bits ignored.
- w  output  1920  expanded schedule, word j at [32*j+31 : 32*j]; words at index >= 4*(Nr+1) are zero.
- nr  output  4  round count latched at start: 10, 12 or 14.
- busy  output  1  high in LOAD and EXPAND.
- done  output  1  level signal, high in DONE; w is stable and complete.

Behaviour:
- Reset (async, any time, including mid-expansion):
  - state = IDLE; w = 0, nr = 0, busy = 0, done = 0.
  - word index = 0; rcon register = 8'h01.
- States: IDLE, LOAD, EXPAND, DONE.
- IDLE or DONE, with start=1 at an edge:
  - latch Nk and nr;
  - clear w;
  - enter LOAD; done drops on that edge.
- start while busy=1: ignored. The expansion in progress is not disturbed.
- LOAD, one cycle:
  - write key words 0..Nk-1 into w;
  - set index = Nk and rcon = 8'h01;
  - enter EXPAND.
- EXPAND, one word per edge, word i = w[i-Nk] XOR temp, with temp = w[i-1], modified as follows:
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) XOR {rcon, 24'h0}; then rcon = xtime(rcon), where xtime = left shift, XOR 8'h1B on carry out;
  - else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - RotWord maps {a,b,c,d} to {b,c,d,a}, with byte a = bits [31:24].
  - SubWord applies the AES S-box to each of the 4 bytes.
  - i mod Nk is tracked by a down-counter; no divider.
- Last word written is i = 4*(nr+1)-1 (43, 51 or 59). On that edge: enter DONE, done=1, busy=0.
- Latency, counting the edge that samples start as edge 0:
  - done is high after edge 1 + (4*(nr+1) - Nk) - 1.
  - That is edge 40 for AES-128, edge 46 for AES-192, edge 52 for AES-256.
- Outputs are registered; the w path has no combinational path from inputs.
- key and key_size are read only on the start edge. Later changes do not affect the expansion in progress.

Decomposition:
- Shared package aes_pkg holds:
  - key_size encodings;
  - NK and NR per key size;
  - MAX_WORDS = 60;
  - the state enum;
  - the xtime function.
- One sub-module, aes_sbox: combinational, 8-bit in, 8-bit out, 256-entry lookup.
- aes_key_expand_seq instantiates aes_sbox four times (SubWord). The same module is reused by the SubBytes stage.

Test Plan:
- AES-128 (FIPS-197 A.1), key = 2b7e151628aed2a6abf7158809cf4f3c:
  - w[4] = a0fafe17, w[43] = b6630ca6;
  - done rises after edge 40; nr = 10;
  - w[44..59] = 0.
- AES-192 (A.2), key = 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w[6] = fe0c91f7, w[51] = 01002202;
  - done after edge 46; nr = 12.
- AES-256 (A.3), key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - w[8] = 9ba35411, w[59] = 706c631e;
  - done after edge 52; nr = 14.
- Start during busy:
  - pulse start with a different key at edge 10 of an AES-128 run;
  - result must equal the original key's schedule, with unchanged timing.
- Reset mid-operation:
  - assert rst at edge 20 of an AES-256 run;
  - w, done and busy clear immediately, without waiting for a clock edge;
  - a fresh AES-128 run afterwards gives w[43] = b6630ca6.
- Back-to-back and reserved size:
  - from DONE (AES-256), start with key_size = 3 and the A.1 key;
  - behaves as AES-128: nr = 10, w[43] = b6630ca6, upper words zeroed.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encodings, per-size Nk/Nr, schedule capacity,
// key-expansion state encoding and the GF(2^8) doubling helper.
package aes_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KS_128  = 2'd0,
        KS_192  = 2'd1,
        KS_256  = 2'd2,
        KS_RSVD = 2'd3
    } keySize_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } aesState_e;

    // The reserved encoding falls through to AES-128 in all three lookups.
    function automatic logic [3:0] nkOf(input logic [1:0] ks);
        case (keySize_e'(ks))
            KS_192:  return 4'd6;
            KS_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nrOf(input logic [1:0] ks);
        case (keySize_e'(ks))
            KS_192:  return 4'd12;
            KS_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] lastWordOf(input logic [1:0] ks);
        case (keySize_e'(ks))
            KS_192:  return 6'd51;
            KS_256:  return 6'd59;
            default: return 6'd43;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational 256-entry lookup.
// Shared by the key schedule (SubWord) and the SubBytes stage.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Row 0 of the table sits in the top bits, so entry x lives at 8*(255-x).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule, one word per clock; done after edge 40/46/52.
// No backpressure: start is ignored while busy, the schedule holds in DONE until restarted.
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               key_size,
    input  logic [255:0]             key,
    output logic [32*MAX_WORDS-1:0]  w,
    output logic [3:0]               nr,
    output logic                     busy,
    output logic                     done
);

    aesState_e   state, stateNext;
    logic [31:0] wMem [MAX_WORDS];
    logic [31:0] keyW [8];
    logic [3:0]  nkReg, nrReg;
    logic [5:0]  idx, lastIdx;
    logic [2:0]  modCnt;
    logic [7:0]  rcon;
    logic [2:0]  lastKey;
    logic [31:0] wPrev, wBack, sbIn, sbOut, temp, newWord;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (start) stateNext = LOAD;
            LOAD:       stateNext = EXPAND;
            EXPAND:     if (idx == lastIdx) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    // LOAD also derives word Nk straight from the latched key, so the
    // schedule finishes Nr*4+4-Nk edges after start.
    assign lastKey = 3'(nkReg - 4'd1);
    assign wPrev   = (state == LOAD) ? keyW[lastKey] : wMem[idx - 6'd1];
    assign wBack   = (state == LOAD) ? keyW[0] : wMem[idx - {2'b00, nkReg}];
    assign sbIn    = (modCnt == 3'd0) ? {wPrev[23:0], wPrev[31:24]} : wPrev;

    for (genvar b = 0; b < 4; b++) begin : gSubWord
        aes_sbox uSbox (
            .x (sbIn[8*b +: 8]),
            .y (sbOut[8*b +: 8])
        );
    end

    // modCnt counts down to the next multiple of Nk; it reads 4 at i mod 8 == 4.
    always_comb begin
        temp = wPrev;
        if (modCnt == 3'd0)
            temp = sbOut ^ {rcon, 24'h0};
        else if (nkReg == 4'd8 && modCnt == 3'd4)
            temp = sbOut;
    end

    assign newWord = wBack ^ temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < MAX_WORDS; j++) wMem[j] <= '0;
            for (int j = 0; j < 8; j++) keyW[j] <= '0;
            nkReg   <= '0;
            nrReg   <= '0;
            idx     <= '0;
            lastIdx <= '0;
            modCnt  <= '0;
            rcon    <= 8'h01;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int j = 0; j < MAX_WORDS; j++) wMem[j] <= '0;
                        for (int j = 0; j < 8; j++) keyW[j] <= key[32*(7-j) +: 32];
                        nkReg   <= nkOf(key_size);
                        nrReg   <= nrOf(key_size);
                        lastIdx <= lastWordOf(key_size);
                        idx     <= {2'b00, nkOf(key_size)};
                        modCnt  <= 3'd0;
                        rcon    <= 8'h01;
                    end
                end
                LOAD, EXPAND: begin
                    if (state == LOAD) begin
                        for (int j = 0; j < 8; j++) begin
                            if (4'(j) < nkReg) wMem[j] <= keyW[j];
                        end
                    end
                    wMem[idx] <= newWord;
                    idx       <= idx + 6'd1;
                    modCnt    <= (modCnt == 3'd0) ? lastKey : modCnt - 3'd1;
                    if (modCnt == 3'd0) rcon <= xtime(rcon);
                end
                default: ;
            endcase
        end
    end

    for (genvar j = 0; j < MAX_WORDS; j++) begin : gFlat
        assign w[32*j +: 32] = wMem[j];
    end

    assign nr   = nrReg;
    assign busy = (state == LOAD) || (state == EXPAND);
    assign done = (state == DONE);

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboarded bench for aes_key_expand_seq: FIPS-197 vectors, restart/reset corner
// cases and random keys checked against a mathematical key-schedule model.
module tb_aes_key_expand_seq;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    key_size = 2'd0;
    logic [255:0]  key = '0;
    logic [1919:0] w;
    logic [3:0]    nr;
    logic          busy, done;

    aes_key_expand_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_size (key_size),
        .key      (key),
        .w        (w),
        .nr       (nr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [1919:0] w;
        int            nr;
        int            doneEdge;
        string         name;
    } exp_t;

    exp_t       sb[$];
    int         nCmp = 0;
    int         nBad = 0;
    int         edgeCnt = 0;
    logic [7:0] refSbox [256];

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            refSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] v);
        return {refSbox[v[31:24]], refSbox[v[23:16]], refSbox[v[15:8]], refSbox[v[7:0]]};
    endfunction

    function automatic int nkFor(input logic [1:0] ks);
        return (ks == 2'd1) ? 6 : (ks == 2'd2) ? 8 : 4;
    endfunction

    function automatic logic [1919:0] refSchedule(input logic [255:0] k, input logic [1:0] ks);
        logic [31:0]   ww [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] flat;
        int nk  = nkFor(ks);
        int tot = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) ww[i] = 32'h0;
        for (int i = 0; i < nk; i++) ww[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            t = ww[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subWord(t);
            end
            ww[i] = ww[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) flat[32*i +: 32] = ww[i];
        return flat;
    endfunction

    task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic checkBus(input string nm, input logic [1919:0] act, input logic [1919:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            for (int j = 0; j < 60; j++) begin
                if (act[32*j +: 32] !== req[32*j +: 32]) begin
                    $display("FAIL %s word %0d: got %h, expected %h", nm, j, act[32*j +: 32], req[32*j +: 32]);
                    break;
                end
            end
        end
    endtask

    // Monitor: every rising done retires the oldest outstanding expansion.
    logic doneQ = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !doneQ) begin
            if (sb.size() == 0) begin
                nCmp++;
                nBad++;
                $display("FAIL unexpected_done at edge %0d: no run outstanding", edgeCnt);
            end else begin
                e = sb.pop_front();
                checkBus({e.name, "_sched"}, w, e.w);
                checkVal({e.name, "_nr"}, 64'(nr), 64'(e.nr));
                checkVal({e.name, "_done_edge"}, 64'(edgeCnt), 64'(e.doneEdge));
                checkVal({e.name, "_busy_low"}, 64'(busy), 64'd0);
            end
        end
        doneQ = done;
    end

    task automatic startRun(input logic [1:0] ks, input logic [255:0] k, input string nm, output int s);
        exp_t e;
        int   nk;
        @(negedge clk);
        key_size = ks;
        key      = k;
        start    = 1'b1;
        s        = edgeCnt + 1;
        nk       = nkFor(ks);
        e.w        = refSchedule(k, ks);
        e.nr       = nk + 6;
        e.doneEdge = s + 4 * (nk + 7) - nk;
        e.name     = nm;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        key_size = 2'($urandom);
        for (int q = 0; q < 8; q++) key[32*q +: 32] = $urandom;
    endtask

    task automatic waitDone(input string nm);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            nCmp++;
            nBad++;
            $display("FAIL %s_timeout: done still %0b after %0d cycles, expected 1", nm, done, n);
        end
    endtask

    task automatic waitUntil(input int e);
        while (edgeCnt < e) @(negedge clk);
    endtask

    task automatic pulseStart(input logic [1:0] ks, input logic [255:0] k);
        start    = 1'b1;
        key_size = ks;
        key      = k;
        @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        int s;
        buildSbox();

        #1 rst = 1'b1;
        #1;
        checkVal("reset_w_zero", 64'(|w), 64'd0);
        checkVal("reset_nr", 64'(nr), 64'd0);
        checkVal("reset_busy", 64'(busy), 64'd0);
        checkVal("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // AES-128 with a competing start at edge 10 that must be ignored.
        startRun(2'd0, KEY128, "a1", s);
        checkVal("a1_busy", 64'(busy), 64'd1);
        waitUntil(s + 9);
        pulseStart(2'd2, KEY256);
        waitDone("a1");
        checkVal("a1_w4", 64'(w[32*4 +: 32]), 64'h a0fafe17);
        checkVal("a1_w43", 64'(w[32*43 +: 32]), 64'h b6630ca6);
        checkVal("a1_upper_zero", 64'(|w[1919:32*44]), 64'd0);

        startRun(2'd1, KEY192, "a2", s);
        waitDone("a2");
        checkVal("a2_w6", 64'(w[32*6 +: 32]), 64'h fe0c91f7);
        checkVal("a2_w51", 64'(w[32*51 +: 32]), 64'h 01002202);
        checkVal("a2_nr", 64'(nr), 64'd12);

        startRun(2'd2, KEY256, "a3", s);
        waitDone("a3");
        checkVal("a3_w8", 64'(w[32*8 +: 32]), 64'h 9ba35411);
        checkVal("a3_w59", 64'(w[32*59 +: 32]), 64'h 706c631e);
        checkVal("a3_nr", 64'(nr), 64'd14);

        // Restart straight from DONE with the reserved size code.
        startRun(2'd3, KEY128, "rsvd", s);
        waitDone("rsvd");
        checkVal("rsvd_nr", 64'(nr), 64'd10);
        checkVal("rsvd_w43", 64'(w[32*43 +: 32]), 64'h b6630ca6);
        checkVal("rsvd_upper_zero", 64'(|w[1919:32*44]), 64'd0);

        // Asynchronous reset in the middle of an AES-256 expansion.
        startRun(2'd2, KEY256, "rst256", s);
        waitUntil(s + 20);
        checkVal("mid_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkVal("mid_rst_w_zero", 64'(|w), 64'd0);
        checkVal("mid_rst_done", 64'(done), 64'd0);
        checkVal("mid_rst_busy", 64'(busy), 64'd0);
        checkVal("mid_rst_nr", 64'(nr), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        startRun(2'd0, KEY128, "post_rst", s);
        waitDone("post_rst");
        checkVal("post_rst_w43", 64'(w[32*43 +: 32]), 64'h b6630ca6);

        for (int r = 0; r < 12; r++) begin
            logic [255:0] k;
            logic [1:0]   ks;
            logic [255:0] junk;
            for (int q = 0; q < 8; q++) begin
                k[32*q +: 32]    = $urandom;
                junk[32*q +: 32] = $urandom;
            end
            ks = 2'($urandom_range(0, 3));
            startRun(ks, k, $sformatf("rnd%0d", r), s);
            if ($urandom_range(0, 1) == 1) begin
                waitUntil(s + $urandom_range(1, 30));
                pulseStart(2'($urandom), junk);
            end
            waitDone($sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        checkVal("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
